// File: rtl/fir_tap_sequencer_if.sv
// fir_tap_sequencer_if: stream, memory-write and MAC control signals between the FIR sequencer and its datapath
interface fir_tap_sequencer_if #(parameter int AW = 6, parameter int DW = 16, parameter int ACCW = 40);
  logic            coef_valid, coef_ready;
  logic [DW-1:0]   coef_data;
  logic            sample_valid, sample_ready;
  logic [DW-1:0]   sample_data;
  logic            reload;
  logic            cmem_we;
  logic [AW-1:0]   cmem_addr;
  logic [DW-1:0]   cmem_wdata;
  logic            imem_we;
  logic [AW-1:0]   imem_addr;
  logic [DW-1:0]   imem_wdata;
  logic [AW-1:0]   rd_coef_addr, rd_samp_addr;
  logic            mac_en, mac_clear;
  logic [ACCW-1:0] mac_result;
  logic            out_valid, out_ready;
  logic [ACCW-1:0] out_data;
  logic            busy;
  modport master (
    input  coef_valid, coef_data, sample_valid, sample_data, reload, mac_result, out_ready,
    output coef_ready, sample_ready, cmem_we, cmem_addr, cmem_wdata, imem_we, imem_addr, imem_wdata,
           rd_coef_addr, rd_samp_addr, mac_en, mac_clear, out_valid, out_data, busy
  );
  modport slave (
    output coef_valid, coef_data, sample_valid, sample_data, reload, mac_result, out_ready,
    input  coef_ready, sample_ready, cmem_we, cmem_addr, cmem_wdata, imem_we, imem_addr, imem_wdata,
           rd_coef_addr, rd_samp_addr, mac_en, mac_clear, out_valid, out_data, busy
  );
endinterface

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: clears sample memory, loads coefficients, then runs NTAPS MAC steps per sample
// over a circular sample buffer and hands each accumulated result out on a valid/ready port.
module fir_tap_sequencer #(
  parameter int NTAPS   = 64,
  parameter int AW      = 6,
  parameter int DW      = 16,
  parameter int ACCW    = 40,
  parameter int MAC_LAT = 2
) (
  input logic clk,
  input logic reset,
  fir_tap_sequencer_if.master bus
);
  localparam int DCW = MAC_LAT > 1 ? $clog2(MAC_LAT) : 1;
  localparam logic [AW-1:0]  LAST   = AW'(NTAPS - 1);
  localparam logic [DCW-1:0] LAST_D = DCW'(MAC_LAT - 1);
  typedef enum logic [2:0] {CLEAR, LOAD_COEF, IDLE, MAC_RUN, DRAIN, OUTPUT} state_t;
  state_t          r_state, w_next;
  logic [AW-1:0]   r_cnt, w_cnt, r_wp, w_wp;
  logic [DCW-1:0]  r_dcnt, w_dcnt;
  logic            r_out_valid, w_out_valid;
  logic [ACCW-1:0] r_out_data, w_out_data;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= CLEAR;
      r_cnt       <= '0;
      r_wp        <= '0;
      r_dcnt      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt;
      r_wp        <= w_wp;
      r_dcnt      <= w_dcnt;
      r_out_valid <= w_out_valid;
      r_out_data  <= w_out_data;
    end
  end
  // Strobes are qualified by reset so every output reads 0 while reset is held, even in CLEAR.
  always_comb begin
    w_next           = r_state;
    w_cnt            = r_cnt;
    w_wp             = r_wp;
    w_dcnt           = r_dcnt;
    w_out_valid      = r_out_valid;
    w_out_data       = r_out_data;
    bus.coef_ready   = 1'b0;
    bus.sample_ready = 1'b0;
    bus.cmem_we      = 1'b0;
    bus.cmem_addr    = '0;
    bus.cmem_wdata   = '0;
    bus.imem_we      = 1'b0;
    bus.imem_addr    = '0;
    bus.imem_wdata   = '0;
    bus.rd_coef_addr = '0;
    bus.rd_samp_addr = '0;
    bus.mac_en       = 1'b0;
    bus.mac_clear    = 1'b0;
    bus.busy         = reset && r_state != IDLE;
    if (reset) begin
      case (r_state)
        CLEAR: begin
          bus.imem_we   = 1'b1;
          bus.imem_addr = r_cnt;
          w_cnt         = r_cnt + 1'b1;
          w_next        = r_cnt == LAST ? LOAD_COEF : CLEAR;
        end
        LOAD_COEF: begin
          bus.coef_ready = 1'b1;
          bus.cmem_we    = bus.coef_valid;
          bus.cmem_addr  = r_cnt;
          bus.cmem_wdata = bus.coef_data;
          if (bus.coef_valid) begin
            w_cnt  = r_cnt + 1'b1;
            w_next = r_cnt == LAST ? IDLE : LOAD_COEF;
          end
        end
        IDLE: begin
          bus.sample_ready = !bus.reload;
          bus.imem_addr    = r_wp;
          bus.imem_wdata   = bus.sample_data;
          if (bus.reload) begin
            w_cnt  = '0;
            w_next = LOAD_COEF;
          end else if (bus.sample_valid) begin
            bus.imem_we = 1'b1;
            w_cnt       = '0;
            w_next      = MAC_RUN;
          end
        end
        MAC_RUN: begin
          bus.mac_en       = 1'b1;
          bus.mac_clear    = r_cnt == '0;
          bus.rd_coef_addr = r_cnt;
          bus.rd_samp_addr = r_wp - r_cnt;
          w_cnt            = r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            w_wp   = r_wp + 1'b1;
            w_dcnt = '0;
            w_next = DRAIN;
          end
        end
        DRAIN: begin
          w_dcnt = r_dcnt + 1'b1;
          if (r_dcnt == LAST_D) begin
            w_out_data  = bus.mac_result;
            w_out_valid = 1'b1;
            w_next      = OUTPUT;
          end
        end
        OUTPUT: begin
          w_out_valid = bus.out_ready ? 1'b0 : r_out_valid;
          w_next      = bus.out_ready ? IDLE : OUTPUT;
        end
        default: w_next = CLEAR;
      endcase
    end
  end
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
endmodule
